// File: rtl/conv_result_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_serializer_if
// Description : Word stream carrying the serialised convolution result, with
//               row-end and frame-end markers alongside the valid/ready pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_result_serializer_if #(
    parameter int WORDLENGTH = 32
);
    logic [WORDLENGTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic                  m_trow_end;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        output m_trow_end,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        input  m_trow_end,
        output m_tready
    );
endinterface
`default_nettype wire

// File: rtl/conv_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_serializer
// Description : Captures a packed convolution result frame and streams it out
//               one word per beat in raster order, with row/column tags and a
//               wrapping count of completed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_result_serializer #(
    parameter  int IMAGE_WIDTH  = 5,
    parameter  int IMAGE_HEIGHT = 5,
    parameter  int KERNAL_SIZE  = 3,
    parameter  int WORDLENGTH   = 32,
    localparam int OUT_W        = IMAGE_WIDTH - KERNAL_SIZE + 1,
    localparam int OUT_H        = IMAGE_HEIGHT - KERNAL_SIZE + 1,
    localparam int N            = OUT_W * OUT_H,
    localparam int ROW_W        = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int COL_W        = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int IDX_W        = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic [N*WORDLENGTH-1:0] res_in,
    input  wire logic                    res_valid,
    output logic                         res_ready,
    conv_result_serializer_if.master     m_axis,
    output logic [ROW_W-1:0]             row_idx,
    output logic [COL_W-1:0]             col_idx,
    output logic                         busy,
    output logic [15:0]                  frame_count
);

    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(OUT_W - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                r_state;
    logic [WORDLENGTH-1:0] r_buf [0:N-1];
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_col;
    logic [IDX_W-1:0]      r_idx;
    logic [15:0]           r_frame_count;
    logic                  r_valid;
    logic                  r_ready;

    logic                  w_col_last;
    logic                  w_last;

    // Markers derive from the position counters; gated so they stay low while idle.
    assign w_col_last = (r_col == C_COL_LAST);
    assign w_last     = w_col_last && (r_row == C_ROW_LAST);

    assign m_axis.m_tdata    = r_buf[r_idx];
    assign m_axis.m_tvalid   = r_valid;
    assign m_axis.m_tlast    = r_valid && w_last;
    assign m_axis.m_trow_end = r_valid && w_col_last;

    assign res_ready   = r_ready;
    assign busy        = r_valid;
    assign row_idx     = r_row;
    assign col_idx     = r_col;
    assign frame_count = r_frame_count;

    // Frame capture, raster-order beat sequencing and frame counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_buf         <= '{default: '0};
            r_row         <= '0;
            r_col         <= '0;
            r_idx         <= '0;
            r_frame_count <= '0;
            r_valid       <= 1'b0;
            r_ready       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (res_valid) begin
                        // Private copy so the producer may move on immediately.
                        for (int i = 0; i < N; i++) begin
                            r_buf[i] <= res_in[i*WORDLENGTH +: WORDLENGTH];
                        end
                        r_row   <= '0;
                        r_col   <= '0;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (m_axis.m_tready) begin
                        if (w_last) begin
                            r_row         <= '0;
                            r_col         <= '0;
                            r_idx         <= '0;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_valid       <= 1'b0;
                            r_ready       <= 1'b1;
                            r_state       <= S_IDLE;
                        end else if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                            r_idx <= r_idx + IDX_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_result_serializer
// Description : Self-checking bench for conv_result_serializer: a 5x5/3x3
//               instance against a frame-queue reference model, plus a
//               single-word 3x3/3x3 instance for the N == 1 and wrap cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_serializer;

    localparam int W     = 32;
    localparam int OUT_W = 3;
    localparam int OUT_H = 3;
    localparam int N     = OUT_W * OUT_H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance (3x3 output frame)
    logic [N*W-1:0] res_in;
    logic           res_valid;
    logic           res_ready;
    logic [1:0]     row_idx;
    logic [1:0]     col_idx;
    logic           busy;
    logic [15:0]    frame_count;

    conv_result_serializer_if #(.WORDLENGTH(W)) s0 ();

    conv_result_serializer #(
        .IMAGE_WIDTH (5),
        .IMAGE_HEIGHT(5),
        .KERNAL_SIZE (3),
        .WORDLENGTH  (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_in     (res_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .m_axis     (s0),
        .row_idx    (row_idx),
        .col_idx    (col_idx),
        .busy       (busy),
        .frame_count(frame_count)
    );

    // Single-word instance (kernel covers the whole image)
    logic [W-1:0]   res_in1;
    logic           res_valid1;
    logic           res_ready1;
    logic [0:0]     row_idx1;
    logic [0:0]     col_idx1;
    logic           busy1;
    logic [15:0]    frame_count1;

    conv_result_serializer_if #(.WORDLENGTH(W)) s1 ();

    conv_result_serializer #(
        .IMAGE_WIDTH (3),
        .IMAGE_HEIGHT(3),
        .KERNAL_SIZE (3),
        .WORDLENGTH  (W)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_in     (res_in1),
        .res_valid  (res_valid1),
        .res_ready  (res_ready1),
        .m_axis     (s1),
        .row_idx    (row_idx1),
        .col_idx    (col_idx1),
        .busy       (busy1),
        .frame_count(frame_count1)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: words of the frame in flight, oldest first
    logic [W-1:0] q[$];
    int           m_fc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the inputs for the next rising edge set:
    // checks outputs against the model, advances the model, moves one cycle.
    task automatic step();
        bit ev;
        int pos;
        ev = (q.size() != 0);
        check("m_tvalid", s0.m_tvalid, ev);
        check("res_ready", res_ready, !ev);
        check("busy", busy, ev);
        check("frame_count", frame_count, m_fc[15:0]);
        if (ev) begin
            pos = N - q.size();
            check("m_tdata", s0.m_tdata, q[0]);
            check("row_idx", row_idx, pos / OUT_W);
            check("col_idx", col_idx, pos % OUT_W);
            check("m_tlast", s0.m_tlast, pos == N - 1);
            check("m_trow_end", s0.m_trow_end, (pos % OUT_W) == OUT_W - 1);
            if (s0.m_tready) begin
                void'(q.pop_front());
                if (q.size() == 0) m_fc = (m_fc + 1) % 65536;
            end
        end else if (res_valid) begin
            for (int i = 0; i < N; i++) q.push_back(res_in[i*W +: W]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) res_in[i*W +: W] = 32'h3F800000 + i;
    endtask

    // One frame through the single-word instance, checked beat by beat
    task automatic single_frame(input logic [W-1:0] word, input logic [15:0] exp_fc);
        res_in1    = word;
        res_valid1 = 1'b1;
        s1.m_tready = 1'b0;
        check("n1_ready_idle", res_ready1, 1'b1);
        @(posedge clk); @(negedge clk);
        res_valid1 = 1'b0;
        res_in1    = ~word;
        check("n1_tvalid", s1.m_tvalid, 1'b1);
        check("n1_tlast", s1.m_tlast, 1'b1);
        check("n1_trow_end", s1.m_trow_end, 1'b1);
        check("n1_tdata", s1.m_tdata, word);
        check("n1_row_col", {row_idx1, col_idx1}, 2'b00);
        @(posedge clk); @(negedge clk);
        check("n1_stall_tvalid", s1.m_tvalid, 1'b1);
        check("n1_stall_tdata", s1.m_tdata, word);
        s1.m_tready = 1'b1;
        @(posedge clk); @(negedge clk);
        s1.m_tready = 1'b0;
        check("n1_tvalid_done", s1.m_tvalid, 1'b0);
        check("n1_ready_done", res_ready1, 1'b1);
        check("n1_frame_count", frame_count1, exp_fc);
    endtask

    initial begin
        res_in      = '0;
        res_valid   = 1'b0;
        s0.m_tready = 1'b0;
        res_in1     = '0;
        res_valid1  = 1'b0;
        s1.m_tready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", s0.m_tvalid, 1'b0);
        check("rst_res_ready", res_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);
        check("rst_flags", {s0.m_tlast, s0.m_trow_end}, 2'b00);
        check("rst_row_col", {row_idx, col_idx}, 4'h0);
        check("rst_tdata", s0.m_tdata, 32'h0);
        check("rst_n1_flags", {s1.m_tvalid, s1.m_tlast, s1.m_trow_end}, 3'b000);
        rst_n = 1'b1;
        step();

        // Ramp frame with continuous ready
        load_ramp();
        res_valid   = 1'b1;
        s0.m_tready = 1'b1;
        step();
        res_valid = 1'b0;
        repeat (11) step();

        // Same frame with ready pattern 1,0,0,1
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            s0.m_tready = ((c % 4) == 0) || ((c % 4) == 3);
            step();
        end

        // Input changed after capture, valid held through the frame
        s0.m_tready = 1'b1;
        res_valid   = 1'b1;
        step();
        res_in = {N{32'hDEADBEEF}};
        repeat (10) step();
        res_valid = 1'b0;
        repeat (11) step();

        // Randomized traffic including NaN / denormal bit patterns
        for (int c = 0; c < 300; c++) begin
            res_valid   = ($urandom_range(0, 3) == 0);
            s0.m_tready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < N; i++) begin
                    case ($urandom_range(0, 5))
                        0:       res_in[i*W +: W] = 32'h7FC00001;
                        1:       res_in[i*W +: W] = 32'h00000001;
                        default: res_in[i*W +: W] = $urandom;
                    endcase
                end
            end
            step();
        end
        res_valid   = 1'b0;
        s0.m_tready = 1'b1;
        repeat (12) step();

        // Reset after four beats of a frame
        load_ramp();
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", s0.m_tvalid, 1'b0);
        check("midrst_res_ready", res_ready, 1'b1);
        check("midrst_frame_count", frame_count, 16'd0);
        check("midrst_busy", busy, 1'b0);
        q.delete();
        m_fc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        repeat (11) step();

        // Single-word frames
        single_frame(32'h12345678, 16'd1);
        single_frame(32'h7F800001, 16'd2);
        single_frame($urandom, 16'd3);

        // Frame counter wrap
        force dut1.r_frame_count = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        release dut1.r_frame_count;
        check("wrap_preload", frame_count1, 16'hFFFF);
        single_frame(32'h00800000, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_result_serializer.md
Name: conv_result_serializer

Overview:
- Reads the flat packed result bus produced by the convolution block and emits it one word per beat on a valid/ready stream, in raster order (row 0 col 0 first).
- Sits between the convolution array and downstream consumers (activation stage, DMA, UART dump).
- Acts as the reader end of the packed-frame interface. It holds a captured copy of the frame, so the convolution block may change its inputs once the frame is accepted.

Parameters:
- imageWidth, 5, input image width in pixels.
- imageHeight, 5, input image height in pixels.
- kernalSize, 3, square kernel edge; requires kernalSize <= imageWidth and kernalSize <= imageHeight.
- wordlength, 32, bits per pixel word (IEEE-754 single, treated as opaque bits).
- Derived: OUT_W = imageWidth-kernalSize+1, OUT_H = imageHeight-kernalSize+1, N = OUT_W*OUT_H.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- res_in  in  N*wordlength  packed frame; word i at res_in[i*wordlength +: wordlength], i = row*OUT_W+col.
- res_valid  in  1  res_in holds a complete frame.
- res_ready  out  1  block can accept a frame.
- m_tdata  out  wordlength  current output word.
- m_tvalid  out  1  m_tdata valid.
- m_tready  in  1  downstream accepts the beat.
- m_tlast  out  1  high on the final word of the frame (index N-1).
- m_trow_end  out  1  high on the last word of each row (col == OUT_W-1).
- row_idx  out  clog2(OUT_H) min 1  row of the current word.
- col_idx  out  clog2(OUT_W) min 1  column of the current word.
- busy  out  1  high in SEND.
- frame_count  out  16  completed frames; wraps from 0xFFFF to 0.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except res_ready, which is 1 after reset; frame buffer cleared.
- Reset mid-frame: m_tvalid drops immediately; the partial frame is discarded; the next frame restarts at index 0.
- State IDLE:
  - res_ready = 1, m_tvalid = 0.
  - On the edge where res_valid && res_ready: register res_in into the frame buffer, clear row/col, go to SEND.
- State SEND:
  - res_ready = 0, m_tvalid = 1, busy = 1.
  - m_tdata = buffer word at row_idx*OUT_W + col_idx.
  - Row/column are tracked with counters; no divider.
- Latency: capture on edge k; the first beat is valid in cycle k+1.
- Beat handshake: a beat transfers on an edge where m_tvalid && m_tready. On transfer:
  - col increments; at OUT_W-1, col wraps to 0 and row increments.
  - If the beat is index N-1 (m_tlast), frame_count increments and state returns to IDLE.
- Stall: while m_tvalid && !m_tready, m_tdata, m_tlast, m_trow_end, row_idx and col_idx hold stable. m_tvalid never drops before the transfer.
- Flags are combinational from the registered counters:
  - m_tlast = (row == OUT_H-1) && (col == OUT_W-1).
  - m_trow_end = (col == OUT_W-1).
- Back-to-back frames: res_ready returns to 1 in the cycle after the last beat, so the minimum frame period is N+1 cycles.
- A res_valid held during SEND is neither captured nor lost; it waits for IDLE.
- res_in changes after capture have no effect on the frame in flight.
- N == 1 (kernalSize equals both image dimensions): the first beat carries m_tlast = 1 and m_trow_end = 1.
- m_tready high while in IDLE: ignored, no state change.
- No arithmetic on data: words pass through bit-exact, including NaN and denormal patterns.

Test Plan:
1. Defaults (N = 9), res_in word i = 32'h3F800000 + i, res_valid pulse, m_tready = 1 constantly -> m_tvalid rises the cycle after capture; words 3F800000..3F800008 appear on 9 consecutive cycles; m_trow_end on indices 2, 5, 8; m_tlast only on index 8; frame_count = 1; res_ready = 1 on the next cycle.
2. Same frame, m_tready toggling 1,0,0,1 repeatedly -> no word is dropped or duplicated; outputs hold during stalls; the 9 words arrive in order; row/col sequence is (0,0)..(2,2).
3. Change res_in to all 32'hDEADBEEF one cycle after capture, with res_valid held high -> the original 9 words are streamed; res_ready stays 0 during SEND; the DEADBEEF frame is captured the cycle after m_tlast and streams as 9 DEADBEEF words.
4. Assert rst_n = 0 after beat 4 of a frame -> m_tvalid = 0 immediately and res_ready = 1 after release; frame_count is unchanged (0); a new frame starts at index 0.
5. Instance with imageWidth = imageHeight = kernalSize = 3 -> a single beat with m_tlast = 1 and m_trow_end = 1; frame_count increments once per frame.
6. Preload frame_count to 0xFFFF by streaming 65535 frames (or force it), then stream one more frame -> frame_count wraps to 0x0000.
